// File: rtl/uart_rx_frame10_if.sv
// FIFO-side write port of the UART receive deserializer.
// The master drives the write strike, the word and the overrun pulse; the FIFO returns its full flag.
interface uart_rx_frame10_if;
  logic [9:0] fifo_data;
  logic       fifo_wrreq;
  logic       fifo_full;
  logic       overrun;

  modport master (output fifo_data, fifo_wrreq, overrun, input fifo_full);
  modport slave  (input fifo_data, fifo_wrreq, overrun, output fifo_full);
endinterface

// File: rtl/uart_rx_frame10.sv
// 16x-oversampled UART receiver writing {frame_err, parity_err, data} words into a FIFO.
// Optional parity bit enabled by defining UART_RX_PARITY_EN (default build is 8N1).
module uart_rx_frame10 #(
  parameter int DIV_W      = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             rxd,
  input  logic [DIV_W-1:0] baud_div,
  output logic             rx_busy,
  uart_rx_frame10_if.master fifo
);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKWAIT} state_t;

  state_t           state, state_next;
  logic             rs_meta, rs;
  logic [DIV_W-1:0] tc, div_m1;
  logic             tick, bit_mid, bit_end;
  logic [3:0]       sc;
  logic             s6, s7, vote;
  logic [7:0]       data_byte;
  logic [2:0]       bit_idx;
  logic             par_err;
  logic             start_det, emit;
  logic [9:0]       word;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      rs_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rs_meta <= rxd;
      rs      <= rs_meta;
    end
  end

  // A zero divider behaves like 1; >= keeps the counter safe if the divider shrinks mid-count.
  assign div_m1 = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
  assign tick   = (tc >= div_m1);

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      tc <= '0;
      sc <= 4'd0;
    end else if (start_det) begin
      tc <= '0;
      sc <= 4'd0;
    end else begin
      tc <= tick ? '0 : tc + DIV_W'(1);
      if (tick) sc <= sc + 4'd1;
    end
  end

  assign bit_mid = tick && (sc == 4'd8);
  assign bit_end = tick && (sc == 4'd15);

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      s6 <= 1'b0;
      s7 <= 1'b0;
    end else begin
      if (tick && sc == 4'd6) s6 <= rs;
      if (tick && sc == 4'd7) s7 <= rs;
    end
  end

  assign vote = (s6 & s7) | (s6 & rs) | (s7 & rs);

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    emit       = 1'b0;
    case (state)
      IDLE: begin
        if (!rs) begin
          start_det  = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_mid && vote) state_next = IDLE;
        else if (bit_end)    state_next = DATA;
      end
      DATA: begin
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_mid) begin
          emit       = 1'b1;
          state_next = vote ? IDLE : BRKWAIT;
        end
      end
      BRKWAIT: begin
        if (rs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx_busy = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      data_byte <= 8'h00;
      bit_idx   <= 3'd0;
      par_err   <= 1'b0;
    end else begin
      if (start_det) begin
        bit_idx <= 3'd0;
        par_err <= 1'b0;
      end else if (state == DATA) begin
        if (bit_mid) data_byte <= {vote, data_byte[7:1]};
        if (bit_end) bit_idx <= bit_idx + 3'd1;
      end else if (state == PARITY && bit_mid) begin
        par_err <= ((^data_byte) ^ vote) != PARITY_ODD;
      end
    end
  end

  assign word = {~vote, PAR_EN ? par_err : 1'b0, data_byte};

  // The word is presented even when dropped, so software can still inspect the overrun character.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      fifo.fifo_data  <= 10'h000;
      fifo.fifo_wrreq <= 1'b0;
      fifo.overrun    <= 1'b0;
    end else begin
      fifo.fifo_wrreq <= 1'b0;
      fifo.overrun    <= 1'b0;
      if (emit) begin
        fifo.fifo_data  <= word;
        fifo.fifo_wrreq <= ~fifo.fifo_full;
        fifo.overrun    <= fifo.fifo_full;
      end
    end
  end

endmodule
